// File: rtl/definitions_pkg.sv
// Shared types for the multicycle RISC-V controller: opcodes, ALU operations,
// immediate formats, controller states and ALU-op classes.
package definitions_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD      = 7'b0000011,
        OPC_MISC_MEM  = 7'b0001111,
        OPC_OP_IMM    = 7'b0010011,
        OPC_AUIPC     = 7'b0010111,
        OPC_OP_IMM_32 = 7'b0011011,
        OPC_STORE     = 7'b0100011,
        OPC_OP        = 7'b0110011,
        OPC_LUI       = 7'b0110111,
        OPC_OP_32     = 7'b0111011,
        OPC_BRANCH    = 7'b1100011,
        OPC_JALR      = 7'b1100111,
        OPC_JAL       = 7'b1101111,
        OPC_SYSTEM    = 7'b1110011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
        ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B, ALU_SH1ADD, ALU_SH2ADD, ALU_SH3ADD
    } alu_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_EXEC_R,
        S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_JALR, S_UPPER, S_TRAP
    } mc_state_e;

    // ALU-op classes chosen by the FSM; alu_decoder refines them with funct bits.
    typedef enum logic [1:0] {ALUOP_ADD, ALUOP_BRANCH, ALUOP_FUNCT, ALUOP_PASS_B} alu_op_e;

endpackage

// File: rtl/alu_decoder.sv
// Turns an ALU-op class plus funct3/funct7 bits into a concrete ALU operation.
// Zba shift-add encodings collapse to add when the extension is disabled.
module alu_decoder
    import definitions_pkg::*;
#(
    parameter int ZBA = 0
) (
    input  alu_op_e    alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    input  logic       funct7_4_i,
    input  logic       funct7_2_i,
    input  logic       op_5_i,
    output alu_e       alu_control_o
);

    logic is_zba;

    // funct7 = 0010000 with funct3 = 010/100/110 on a register-register op.
    assign is_zba = op_5_i && funct7_4_i && !funct7_5_i && !funct7_2_i &&
                    !funct3_i[0] && (funct3_i[2:1] != 2'b00);

    always_comb begin
        // NOTE: default assigned first so every path drives the output and no latch is inferred.
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_ADD:    alu_control_o = ALU_ADD;
            ALUOP_PASS_B: alu_control_o = ALU_PASS_B;
            ALUOP_BRANCH: begin
                case (funct3_i[2:1])
                    2'b10:   alu_control_o = ALU_SLT;
                    2'b11:   alu_control_o = ALU_SLTU;
                    default: alu_control_o = ALU_SUB;
                endcase
            end
            ALUOP_FUNCT: begin
                if (is_zba) begin
                    if (ZBA != 0) begin
                        case (funct3_i[2:1])
                            2'b01:   alu_control_o = ALU_SH1ADD;
                            2'b10:   alu_control_o = ALU_SH2ADD;
                            default: alu_control_o = ALU_SH3ADD;
                        endcase
                    end
                end else begin
                    case (funct3_i)
                        3'b000:  alu_control_o = (op_5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
                        3'b001:  alu_control_o = ALU_SLL;
                        3'b010:  alu_control_o = ALU_SLT;
                        3'b011:  alu_control_o = ALU_SLTU;
                        3'b100:  alu_control_o = ALU_XOR;
                        3'b101:  alu_control_o = funct7_5_i ? ALU_SRA : ALU_SRL;
                        3'b110:  alu_control_o = ALU_OR;
                        default: alu_control_o = ALU_AND;
                    endcase
                end
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch, decode, memory,
// execute and write-back steps, with a sticky illegal-opcode trap.
module mc_controller
    import definitions_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ZBA  = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  opcode_e    op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    input  logic       funct7_4_i,
    input  logic       funct7_2_i,
    input  logic       zero_i,
    input  logic       less_than_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_write_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] result_src_o,
    output imm_src_e   imm_src_o,
    output alu_e       alu_control_o,
    output logic       data_memory_sign_o,
    output logic [1:0] data_memory_size_o,
    output logic       word_32_o,
    output logic       illegal_o
);

    localparam bit Rv64 = (XLEN == 64);

    mc_state_e state_q, state_d;
    logic      illegal_q, illegal_d;
    alu_op_e   alu_op;
    logic      mem_req, mem_write, ir_write, pc_write, reg_write;
    logic      is_w_op, branch_taken;

    assign is_w_op = Rv64 && ((op_i == OPC_OP_32) || (op_i == OPC_OP_IMM_32));

    always_comb begin
        case (funct3_i)
            3'b000:         branch_taken = zero_i;
            3'b001:         branch_taken = !zero_i;
            3'b100, 3'b110: branch_taken = less_than_i;
            3'b101, 3'b111: branch_taken = !less_than_i;
            default:        branch_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal_d = illegal_q || (state_d == S_TRAP);

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        adr_src_o    = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        result_src_o = 2'b00;
        imm_src_o    = IMM_I;
        alu_op       = ALUOP_ADD;
        word_32_o    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req      = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                if (mem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                imm_src_o   = IMM_B;
                case (op_i)
                    OPC_LOAD, OPC_STORE: state_d = S_MEM_ADR;
                    OPC_OP:              state_d = S_EXEC_R;
                    OPC_OP_32:           state_d = Rv64 ? S_EXEC_R : S_TRAP;
                    OPC_OP_IMM:          state_d = S_EXEC_I;
                    OPC_OP_IMM_32:       state_d = Rv64 ? S_EXEC_I : S_TRAP;
                    OPC_BRANCH:          state_d = S_BRANCH;
                    OPC_JAL:             state_d = S_JAL;
                    OPC_JALR:            state_d = S_JALR;
                    OPC_LUI, OPC_AUIPC:  state_d = S_UPPER;
                    default:             state_d = S_TRAP;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                imm_src_o   = (op_i == OPC_STORE) ? IMM_S : IMM_I;
                state_d     = (op_i == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req   = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_MEM_WB: begin
                reg_write    = 1'b1;
                result_src_o = 2'b01;
                state_d      = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a_o = 2'b10;
                alu_op      = ALUOP_FUNCT;
                word_32_o   = is_w_op;
                state_d     = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                alu_op      = ALUOP_FUNCT;
                word_32_o   = is_w_op;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                word_32_o = is_w_op;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = 2'b10;
                alu_op      = ALUOP_BRANCH;
                pc_write    = branch_taken;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target held in ALU-out while the ALU forms old PC + 4 for rd.
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_write    = 1'b1;
                state_d     = S_ALU_WB;
            end
            S_JALR: begin
                alu_src_a_o  = 2'b10;
                alu_src_b_o  = 2'b01;
                result_src_o = 2'b10;
                pc_write     = 1'b1;
                state_d      = S_ALU_WB;
            end
            S_UPPER: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                imm_src_o   = IMM_U;
                alu_op      = (op_i == OPC_LUI) ? ALUOP_PASS_B : ALUOP_ADD;
                state_d     = S_ALU_WB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are gated by reset so an open access is abandoned the moment rst_ni falls.
    assign mem_req_o   = mem_req && rst_ni;
    assign mem_write_o = mem_write && rst_ni;
    assign ir_write_o  = ir_write && rst_ni;
    assign pc_write_o  = pc_write && rst_ni;
    assign reg_write_o = reg_write && rst_ni;
    assign illegal_o   = illegal_q;

    assign data_memory_sign_o = funct3_i[2];
    assign data_memory_size_o = funct3_i[1:0];

    alu_decoder #(.ZBA(ZBA)) u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3_i),
        .funct7_5_i    (funct7_5_i),
        .funct7_4_i    (funct7_4_i),
        .funct7_2_i    (funct7_2_i),
        .op_5_i        (op_i[5]),
        .alu_control_o (alu_control_o)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: a driver issues whole instructions and
// queues the per-cycle expected controls; a monitor compares every cycle.
module tb_mc_controller;
    import definitions_pkg::*;

    localparam int XLEN = 32;
    localparam int ZBA  = 0;

    logic       clk, rst_ni;
    opcode_e    op_i;
    logic [2:0] funct3_i;
    logic       funct7_5_i, funct7_4_i, funct7_2_i, zero_i, less_than_i, mem_ready_i;
    logic       mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o;
    logic [1:0] alu_src_a_o, alu_src_b_o, result_src_o, data_memory_size_o;
    imm_src_e   imm_src_o;
    alu_e       alu_control_o;
    logic       data_memory_sign_o, word_32_o, illegal_o;

    mc_controller #(.XLEN(XLEN), .ZBA(ZBA)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .op_i(op_i), .funct3_i(funct3_i),
        .funct7_5_i(funct7_5_i), .funct7_4_i(funct7_4_i), .funct7_2_i(funct7_2_i),
        .zero_i(zero_i), .less_than_i(less_than_i), .mem_ready_i(mem_ready_i),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .adr_src_o(adr_src_o),
        .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .result_src_o(result_src_o),
        .imm_src_o(imm_src_o), .alu_control_o(alu_control_o),
        .data_memory_sign_o(data_memory_sign_o), .data_memory_size_o(data_memory_size_o),
        .word_32_o(word_32_o), .illegal_o(illegal_o)
    );

    typedef struct packed {
        logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
        logic [1:0] src_a, src_b, res;
        logic [2:0] imm;
        logic [3:0] alu;
        logic       sign;
        logic [1:0] size;
        logic       w32, illegal;
    } obs_t;

    typedef enum {P_FETCH, P_DECODE, P_MEM_ADR, P_MEM_READ, P_MEM_WB, P_MEM_WRITE, P_EXEC_R,
                  P_EXEC_I, P_ALU_WB, P_BRANCH, P_JAL, P_JALR, P_UPPER, P_TRAP} phase_e;

    obs_t  exp_q[$];
    obs_t  mask_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;
    int    rw_cnt = 0;
    int    n_instr = 0;

    opcode_e    cur_op;
    logic [2:0] cur_f3, cur_f7;
    logic       cur_z, cur_lt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t actual();
        obs_t a;
        a = '{mem_req_o, mem_write_o, adr_src_o, ir_write_o, pc_write_o, reg_write_o,
              alu_src_a_o, alu_src_b_o, result_src_o, imm_src_o, alu_control_o,
              data_memory_sign_o, data_memory_size_o, word_32_o, illegal_o};
        return a;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp, input obs_t care);
        total++;
        if (((act ^ exp) & care) != '0) begin
            bad++;
            $display("FAIL %s: got=%h want=%h care=%h", name, act, exp, care);
        end
    endtask

    function automatic obs_t enable_mask();
        obs_t m;
        m = '0;
        m.mem_req = 1'b1; m.mem_write = 1'b1; m.ir_write = 1'b1;
        m.pc_write = 1'b1; m.reg_write = 1'b1; m.illegal = 1'b1;
        return m;
    endfunction

    // RISC-V semantics of the funct fields, written mnemonic by mnemonic.
    function automatic alu_e ref_alu(input opcode_e op, input logic [2:0] f3, input logic [2:0] f7);
        bit reg_reg;
        reg_reg = (op == OPC_OP) || (op == OPC_OP_32);
        if (reg_reg && f7 == 3'b010 && (f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd6)) begin
            if (ZBA == 0) return ALU_ADD;
            return (f3 == 3'd2) ? ALU_SH1ADD : (f3 == 3'd4) ? ALU_SH2ADD : ALU_SH3ADD;
        end
        case (f3)
            3'd0: return (reg_reg && f7[2]) ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return f7[2] ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input logic z, input logic lt);
        case (f3)
            3'd0: return z;        // beq
            3'd1: return !z;       // bne
            3'd4, 3'd6: return lt; // blt, bltu
            3'd5, 3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void push(input phase_e p, input bit ready);
        obs_t e, m;
        bit   w_op;
        e = '0;
        m = enable_mask();
        m.sign = 1'b1; m.size = 2'b11; m.w32 = 1'b1;
        e.sign = cur_f3[2];
        e.size = cur_f3[1:0];
        w_op = (XLEN == 64) && (cur_op == OPC_OP_32 || cur_op == OPC_OP_IMM_32);
        e.w32 = w_op && (p == P_EXEC_R || p == P_EXEC_I || p == P_ALU_WB);
        e.illegal = (p == P_TRAP);
        case (p)
            P_FETCH: begin
                e.mem_req = 1'b1; m.adr_src = 1'b1;
                if (ready) begin
                    e.ir_write = 1'b1; e.pc_write = 1'b1;
                    e.src_a = 2'b00; e.src_b = 2'b10; e.res = 2'b10; e.alu = ALU_ADD;
                    m.src_a = '1; m.src_b = '1; m.res = '1; m.alu = '1;
                end
            end
            P_DECODE: begin
                e.src_a = 2'b01; e.src_b = 2'b01; e.imm = IMM_B; e.alu = ALU_ADD;
                m.src_a = '1; m.src_b = '1; m.imm = '1; m.alu = '1;
            end
            P_MEM_ADR, P_JALR: begin
                e.src_a = 2'b10; e.src_b = 2'b01; e.alu = ALU_ADD;
                m.src_a = '1; m.src_b = '1; m.alu = '1;
                e.pc_write = (p == P_JALR);
            end
            P_MEM_READ: begin
                e.mem_req = 1'b1; e.adr_src = 1'b1; m.adr_src = 1'b1;
            end
            P_MEM_WRITE: begin
                e.mem_req = 1'b1; e.mem_write = 1'b1; e.adr_src = 1'b1; m.adr_src = 1'b1;
            end
            P_MEM_WB: begin
                e.reg_write = 1'b1; e.res = 2'b01; m.res = '1;
            end
            P_EXEC_R, P_EXEC_I: begin
                e.src_a = 2'b10; e.src_b = (p == P_EXEC_I) ? 2'b01 : 2'b00;
                e.alu = ref_alu(cur_op, cur_f3, cur_f7);
                m.src_a = '1; m.src_b = '1; m.alu = '1;
            end
            P_ALU_WB: begin
                e.reg_write = 1'b1; e.res = 2'b00; m.res = '1;
            end
            P_BRANCH: begin
                e.pc_write = ref_taken(cur_f3, cur_z, cur_lt);
                if (e.pc_write) m.res = '1;
            end
            P_JAL: begin
                e.pc_write = 1'b1; e.res = 2'b00; m.res = '1;
            end
            default: ;
        endcase
        exp_q.push_back(e);
        mask_q.push_back(m);
        name_q.push_back($sformatf("%s#%0d", p.name(), n_instr));
    endfunction

    task automatic cycle(input phase_e p, input bit ready);
        @(posedge clk);
        #1;
        rst_ni      = 1'b1;
        op_i        = cur_op;
        funct3_i    = cur_f3;
        funct7_5_i  = cur_f7[2];
        funct7_4_i  = cur_f7[1];
        funct7_2_i  = cur_f7[0];
        zero_i      = cur_z;
        less_than_i = cur_lt;
        mem_ready_i = ready;
        push(p, ready);
    endtask

    task automatic mem_phase(input phase_e p, input int waits);
        repeat (waits) cycle(p, 1'b0);
        cycle(p, 1'b1);
    endtask

    function automatic bit rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input opcode_e op, input logic [2:0] f3, input logic [2:0] f7,
                             input bit z, input bit lt, input int fw, input int mw);
        n_instr++;
        cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z; cur_lt = lt;
        mem_phase(P_FETCH, fw);
        cycle(P_DECODE, rnd_bit());
        case (op)
            OPC_LOAD: begin
                cycle(P_MEM_ADR, rnd_bit()); mem_phase(P_MEM_READ, mw); cycle(P_MEM_WB, rnd_bit());
            end
            OPC_STORE: begin
                cycle(P_MEM_ADR, rnd_bit()); mem_phase(P_MEM_WRITE, mw);
            end
            OPC_OP, OPC_OP_32: begin
                if (op == OPC_OP || XLEN == 64) begin
                    cycle(P_EXEC_R, rnd_bit()); cycle(P_ALU_WB, rnd_bit());
                end else cycle(P_TRAP, rnd_bit());
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                if (op == OPC_OP_IMM || XLEN == 64) begin
                    cycle(P_EXEC_I, rnd_bit()); cycle(P_ALU_WB, rnd_bit());
                end else cycle(P_TRAP, rnd_bit());
            end
            OPC_BRANCH: cycle(P_BRANCH, rnd_bit());
            OPC_JAL:    begin cycle(P_JAL, rnd_bit());   cycle(P_ALU_WB, rnd_bit()); end
            OPC_JALR:   begin cycle(P_JALR, rnd_bit());  cycle(P_ALU_WB, rnd_bit()); end
            OPC_LUI, OPC_AUIPC: begin cycle(P_UPPER, rnd_bit()); cycle(P_ALU_WB, rnd_bit()); end
            default:    cycle(P_TRAP, rnd_bit());
        endcase
    endtask

    // Monitor: every cycle that has a queued expectation is compared on the falling edge.
    initial begin
        obs_t  e, m;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                m = mask_q.pop_front();
                n = name_q.pop_front();
                check(n, actual(), e, m);
            end
        end
    end

    always @(negedge clk) if (reg_write_o) rw_cnt++;

    initial begin
        opcode_e legal[9];
        obs_t    e;
        int      rw_before;
        legal = '{OPC_LOAD, OPC_STORE, OPC_OP, OPC_OP_IMM, OPC_BRANCH, OPC_JAL,
                  OPC_JALR, OPC_LUI, OPC_AUIPC};
        rst_ni = 1'b0; op_i = OPC_OP; funct3_i = 3'd0; funct7_5_i = 1'b0; funct7_4_i = 1'b0;
        funct7_2_i = 1'b0; zero_i = 1'b0; less_than_i = 1'b0; mem_ready_i = 1'b1;
        #3;
        check("reset_idle", actual(), '0, enable_mask());

        // add x3,x1,x2 with zero-wait memory: one write-back pulse.
        rw_before = rw_cnt;
        run_instr(OPC_OP, 3'd0, 3'b000, 1'b0, 1'b0, 0, 0);
        @(negedge clk); #1;
        total++;
        if (rw_cnt - rw_before != 1) begin
            bad++;
            $display("FAIL add_reg_write_pulses: got=%0d want=1", rw_cnt - rw_before);
        end

        run_instr(OPC_LOAD, 3'b010, 3'b000, 1'b0, 1'b0, 1, 3);     // lw, 3 read waits
        run_instr(OPC_BRANCH, 3'b000, 3'b000, 1'b1, 1'b0, 0, 0);   // beq taken
        run_instr(OPC_BRANCH, 3'b000, 3'b000, 1'b0, 1'b1, 0, 0);   // beq not taken
        run_instr(OPC_BRANCH, 3'b111, 3'b000, 1'b0, 1'b0, 0, 0);   // bgeu taken
        run_instr(OPC_BRANCH, 3'b010, 3'b000, 1'b1, 1'b1, 0, 0);   // reserved, never taken
        run_instr(OPC_OP, 3'b100, 3'b010, 1'b0, 1'b0, 0, 0);       // sh2add encoding
        run_instr(OPC_STORE, 3'b001, 3'b000, 1'b0, 1'b0, 2, 0);    // zero-wait store

        for (int i = 0; i < 250; i++)
            run_instr(legal[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), rnd_bit(), rnd_bit(),
                      $urandom_range(0, 3), $urandom_range(0, 3));

        // Reset in the middle of a stalled store.
        n_instr++;
        cur_op = OPC_STORE; cur_f3 = 3'b010; cur_f7 = 3'b000;
        mem_phase(P_FETCH, 0);
        cycle(P_DECODE, 1'b0);
        cycle(P_MEM_ADR, 1'b0);
        cycle(P_MEM_WRITE, 1'b0);
        @(posedge clk); #1;
        mem_ready_i = 1'b0;
        e = '0; e.mem_req = 1'b1; e.mem_write = 1'b1;
        check("store_before_reset", actual(), e, enable_mask());
        rst_ni = 1'b0;
        #1;
        check("store_reset_abort", actual(), '0, enable_mask());
        run_instr(OPC_OP_IMM, 3'b101, 3'b100, 1'b0, 1'b0, 0, 0);   // srai after restart

        // Unsupported opcodes trap and stay trapped until reset.
        run_instr(OPC_OP_32, 3'd0, 3'b000, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(P_TRAP, rnd_bit());
        @(posedge clk); #1;
        rst_ni = 1'b0;
        #1;
        check("trap_reset_clears", actual(), '0, enable_mask());
        run_instr(OPC_SYSTEM, 3'd0, 3'b000, 1'b0, 1'b0, 1, 0);
        cycle(P_TRAP, 1'b1);
        @(posedge clk); #1;
        rst_ni = 1'b0;
        #1;
        check("trap2_reset_clears", actual(), '0, enable_mask());
        run_instr(OPC_JAL, 3'd0, 3'b000, 1'b0, 1'b0, 0, 0);

        @(negedge clk); #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got=%0d pending want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter ZBA, default 0; 1 enables sh1add/sh2add/sh3add decode.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; the ports are clk_i and rst_ni.
REQ-004 Ports (name  dir  width  meaning):
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- op_i  in  opcode_e  instruction-register opcode
- funct3_i  in  3  instruction funct3
- funct7_5_i, funct7_4_i, funct7_2_i  in  1 each  instruction funct7 bits
- zero_i, less_than_i  in  1 each  ALU flags; less_than_i is signed or unsigned per funct3
- mem_ready_i  in  1  memory completes the current access
- mem_req_o  out  1  memory access request
- mem_write_o  out  1  store request
- adr_src_o  out  1  address select: 0 = PC, 1 = ALU-out register
- ir_write_o, pc_write_o, reg_write_o  out  1 each  register enables
- alu_src_a_o  out  2  00 = PC, 01 = old PC, 10 = rs1
- alu_src_b_o  out  2  00 = rs2, 01 = immediate, 10 = constant 4
- result_src_o  out  2  00 = ALU-out register, 01 = read data, 10 = ALU result
- imm_src_o  out  imm_src_e  immediate format
- alu_control_o  out  alu_e  ALU operation
- data_memory_sign_o  out  1  load sign bit, equal to funct3[2]
- data_memory_size_o  out  2  access size, equal to funct3[1:0]
- word_32_o  out  1  32-bit word operation; held 0 when XLEN = 32
- illegal_o  out  1  sticky illegal-opcode flag

Function
REQ-005 SHALL implement a Moore FSM with these states: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR, UPPER, TRAP.
REQ-006 FETCH SHALL assert mem_req_o with adr_src_o = 0 and hold state while mem_ready_i = 0.
- In the cycle mem_ready_i = 1, it SHALL pulse ir_write_o and pc_write_o, set alu_src_a_o = 00, alu_src_b_o = 10, result_src_o = 10, and go to DECODE.
REQ-007 DECODE SHALL compute the branch target with alu_src_a_o = 01, alu_src_b_o = 01 and imm_src_o = B, then dispatch on op_i:
- load or store -> MEM_ADR
- OP, and OP_32 when XLEN = 64 -> EXEC_R
- OP_IMM, and OP_IMM_32 when XLEN = 64 -> EXEC_I
- BRANCH -> BRANCH
- JAL -> JAL
- JALR -> JALR
- LUI or AUIPC -> UPPER
- any other opcode -> TRAP
REQ-008 MEM_ADR SHALL compute rs1 + immediate, then go to MEM_READ for a load or MEM_WRITE for a store.
REQ-009 MEM_READ and MEM_WRITE SHALL assert mem_req_o with adr_src_o = 1, and hold until mem_ready_i = 1.
- MEM_WRITE SHALL assert mem_write_o for its whole duration.
- On completion, MEM_READ SHALL go to MEM_WB and MEM_WRITE SHALL go to FETCH.
REQ-010 MEM_WB SHALL assert reg_write_o with result_src_o = 01, then go to FETCH.
REQ-011 EXEC_R and EXEC_I SHALL go to ALU_WB.
- ALU_WB SHALL assert reg_write_o with result_src_o = 00, then go to FETCH.
REQ-012 BRANCH SHALL assert pc_write_o with result_src_o = 00 when the branch is taken, then go to FETCH.
- Taken conditions: beq when zero_i; bne when !zero_i; blt/bltu when less_than_i; bge/bgeu when !less_than_i.
- funct3 010 and 011 SHALL never be taken.
REQ-013 JAL and JALR SHALL go to ALU_WB with pc_write_o = 1.
- JAL SHALL load PC from the DECODE-computed target.
- JALR SHALL load PC from rs1 + immediate.
- Both SHALL write old PC + 4 to rd.
REQ-014 UPPER SHALL compute the LUI or AUIPC result, then go to ALU_WB.
REQ-015 TRAP SHALL set illegal_o = 1 and hold all enables at 0; it SHALL be absorbing until reset.
REQ-016 alu_control_o SHALL be produced by ALU-op classes:
- add for address and PC arithmetic
- subtract/compare for BRANCH
- funct-decoded for EXEC_R and EXEC_I
- Zba encodings SHALL decode to add when ZBA = 0
REQ-017 word_32_o SHALL be 1 only in EXEC_R, EXEC_I and ALU_WB for OP_32 or OP_IMM_32.
REQ-018 All enables SHALL be 0 in any state not listed as asserting them.
- mem_write_o SHALL never be 1 without mem_req_o.
REQ-019 The stall behaviour in REQ-006 and REQ-009 SHALL tolerate mem_ready_i = 1 on the first request cycle, giving zero wait states.

Reset
REQ-020 rst_ni low SHALL immediately force state FETCH and illegal_o = 0, aborting any state, including an open memory access.
REQ-021 During reset all enables SHALL be 0; after release FETCH SHALL assert mem_req_o on the first clock.

Structure
REQ-022 definitions_pkg SHALL hold opcode_e, alu_e, imm_src_e, a new mc_state_e, and a new alu_op_e.
REQ-023 funct decode SHALL live in the existing alu_decoder sub-module; the FSM and output decode SHALL stay in mc_controller.

Verification
REQ-024 add x3,x1,x2 with zero-wait memory -> FETCH, DECODE, EXEC_R, ALU_WB, FETCH over 4 cycles, with exactly one reg_write_o pulse.
REQ-025 lw with mem_ready_i low for 3 cycles in MEM_READ -> mem_req_o held for 4 cycles, then MEM_WB writes with result_src_o = 01.
REQ-026 beq with zero_i = 1 -> one pc_write_o pulse in BRANCH; with zero_i = 0 -> none; bgeu with less_than_i = 0 -> taken.
REQ-027 XLEN = 32 with an OP_32 opcode -> TRAP, illegal_o = 1 and held; rst_ni pulse -> illegal_o = 0 and FETCH.
REQ-028 rst_ni asserted mid-MEM_WRITE -> mem_write_o drops asynchronously and the FSM restarts in FETCH.
